// File: rtl/uart_rx_os.sv
// Purpose : 16x oversampling UART receiver (5..9 data bits, optional parity, 1/2 stop bits)
//           with 3-sample majority vote, parity/framing flags, overrun and break pulses.
// Latency : word presented 1 clock after the mid-point (tick 9) decision of the final stop bit.
// Backpressure: valid/ready; a word committed while storage is full is dropped and o_overrun pulses.
//
// Optional feature macro: UART_RX_FIFO_EN -- replaces the single holding register with a
// FIFO_DEPTH-entry FIFO whose head drives o_data and the flags.
//
// Ports:
//   i_clk_sys, i_rst_n (async, active-low)  clock / reset
//   i_uart_rx                               asynchronous serial line, idle high
//   o_data, o_parity_err, o_frame_err       received word and its flags
//   o_valid / i_ready                       output handshake
//   o_overrun, o_break                      one-cycle event pulses
//   o_busy                                  receiver FSM outside IDLE
module uart_rx_os #(
    parameter int CLK_FRE     = 50,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_ON   = 0,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  i_clk_sys,
    input  logic                  i_rst_n,
    input  logic                  i_uart_rx,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_overrun,
    output logic                  o_break,
    output logic                  o_busy
);

    localparam int          DIV    = CLK_FRE * 1000000 / (BAUD_RATE * 16);
    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
    localparam logic        PAR_T  = (PARITY_TYPE != 0);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || DIV < 1) begin : g_bad_cfg
        $error("uart_rx_os: illegal parameter combination");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------------------------------------------------------- input sync
    logic rx_meta, rx_sync, rx_prev;
    logic fall_edge;

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall_edge = rx_prev & ~rx_sync;

    // ---------------------------------------------------------------- tick / sample counters
    logic [15:0] div_cnt_q;
    logic [3:0]  samp_cnt_q;
    logic        tick, tick_clr;
    logic        smp0_q, smp1_q, maj;
    logic        bit_mid, bit_end;

    assign tick = (div_cnt_q == DIV_M1);

    // tick_clr re-phases both counters to the start edge so tick 15 lands on the bit boundary
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt_q  <= '0;
            samp_cnt_q <= '0;
            smp0_q     <= 1'b1;
            smp1_q     <= 1'b1;
        end else if (tick_clr) begin
            div_cnt_q  <= '0;
            samp_cnt_q <= '0;
        end else begin
            div_cnt_q <= tick ? '0 : div_cnt_q + 16'd1;
            if (tick) begin
                samp_cnt_q <= samp_cnt_q + 4'd1;
                if (samp_cnt_q == 4'd7) smp0_q <= rx_sync;
                if (samp_cnt_q == 4'd8) smp1_q <= rx_sync;
            end
        end
    end

    // third capture is the live synchronised value at tick 9
    assign maj     = (smp0_q & smp1_q) | (smp0_q & rx_sync) | (smp1_q & rx_sync);
    assign bit_mid = tick && (samp_cnt_q == 4'd9);
    assign bit_end = tick && (samp_cnt_q == 4'd15);

    // ---------------------------------------------------------------- receive FSM
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  zero_q, zero_d;      // every bit so far sampled low
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  stop2_q, stop2_d;    // currently in the second stop bit
    logic                  brk_wait_q, brk_wait_d;
    logic [3:0]            hi_cnt_q;
    logic                  commit, brk_pulse;

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            zero_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stop2_q    <= 1'b0;
            brk_wait_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            zero_q     <= zero_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            stop2_q    <= stop2_d;
            brk_wait_q <= brk_wait_d;
        end
    end

    // counts consecutive high ticks while holding off after a break
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hi_cnt_q <= '0;
        end else if (brk_pulse) begin
            hi_cnt_q <= '0;
        end else if (brk_wait_q && tick) begin
            hi_cnt_q <= rx_sync ? hi_cnt_q + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        zero_d     = zero_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        stop2_d    = stop2_q;
        brk_wait_d = brk_wait_q;
        tick_clr   = 1'b0;
        commit     = 1'b0;
        brk_pulse  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (brk_wait_q) begin
                    if (tick && rx_sync && hi_cnt_q == 4'd15) brk_wait_d = 1'b0;
                end else if (fall_edge) begin
                    state_d  = S_START;
                    tick_clr = 1'b1;
                end
            end
            S_START: begin
                if (bit_mid && maj) begin
                    state_d = S_IDLE;           // glitch, not a start bit
                end else if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                    zero_d    = 1'b1;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                    stop2_d   = 1'b0;
                end
            end
            S_DATA: begin
                if (bit_mid) begin
                    shreg_d   = {maj, shreg_q[DATA_WIDTH-1:1]};
                    zero_d    = zero_q & ~maj;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                // bit_cnt already advanced at mid-bit, so the last bit ends at DATA_WIDTH
                if (bit_end && bit_cnt_q == 4'(DATA_WIDTH)) begin
                    state_d = (PARITY_ON != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_mid) begin
                    perr_d = maj ^ (^shreg_q) ^ PAR_T;
                    zero_d = zero_q & ~maj;
                end
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_mid && !stop2_q) begin
                    ferr_d = ~maj;
                    if (zero_q && !maj) begin
                        brk_pulse  = 1'b1;
                        brk_wait_d = 1'b1;
                        state_d    = S_IDLE;
                    end else if (STOP_BITS == 1) begin
                        commit  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (bit_mid && stop2_q) begin
                    commit  = 1'b1;             // second stop bit value is ignored
                    state_d = S_IDLE;
                end
                if (bit_end && !stop2_q) stop2_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_busy = (state_q != S_IDLE);

    // ---------------------------------------------------------------- event pulses
    logic pop, overrun_d;

    assign pop = o_valid & i_ready;

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_break   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_break   <= brk_pulse;
            o_overrun <= overrun_d;
        end
    end

`ifdef UART_RX_FIFO_EN
    // ---------------------------------------------------------------- output FIFO
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH+1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  full, push;

    assign full      = (count_q == (AW + 1)'(FIFO_DEPTH));
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push      = commit & (~full | pop);
    assign overrun_d = commit & full & ~pop;

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {perr_q, ferr_d, shreg_q};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign o_valid      = (count_q != '0);
    assign o_parity_err = mem_q[rd_ptr_q][DATA_WIDTH+1];
    assign o_frame_err  = mem_q[rd_ptr_q][DATA_WIDTH];
    assign o_data       = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
`else
    // ---------------------------------------------------------------- holding register
    assign overrun_d = commit & o_valid & ~i_ready;

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data       <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_valid      <= 1'b0;
        end else if (commit && (!o_valid || i_ready)) begin
            o_data       <= shreg_q;
            o_parity_err <= perr_q;
            o_frame_err  <= ferr_d;
            o_valid      <= 1'b1;
        end else if (pop) begin
            o_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
module tb_uart_rx_os;

    localparam int BIT = 432;   // 50 MHz / 115200 baud with DIV = 27

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       rdy_a = 1'b1, rdy_b = 1'b1;
    logic [7:0] d_a, d_b;
    logic       pe_a, fe_a, val_a, ovr_a, brk_a, busy_a;
    logic       pe_b, fe_b, val_b, ovr_b, brk_b, busy_b;

    always #10 clk = ~clk;

    // 8N1 receiver
    uart_rx_os #(.CLK_FRE(50), .BAUD_RATE(115200), .DATA_WIDTH(8), .PARITY_ON(0),
                 .PARITY_TYPE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
        .i_clk_sys(clk), .i_rst_n(rst_n), .i_uart_rx(rx_a),
        .o_data(d_a), .o_parity_err(pe_a), .o_frame_err(fe_a), .o_valid(val_a),
        .i_ready(rdy_a), .o_overrun(ovr_a), .o_break(brk_a), .o_busy(busy_a));

    // 8E1 receiver
    uart_rx_os #(.CLK_FRE(50), .BAUD_RATE(115200), .DATA_WIDTH(8), .PARITY_ON(1),
                 .PARITY_TYPE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_b (
        .i_clk_sys(clk), .i_rst_n(rst_n), .i_uart_rx(rx_b),
        .o_data(d_b), .o_parity_err(pe_b), .o_frame_err(fe_b), .o_valid(val_b),
        .i_ready(rdy_b), .o_overrun(ovr_b), .o_break(brk_b), .o_busy(busy_b));

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard entries: {parity_err, frame_err, data}
    logic [9:0] q_a[$];
    logic [9:0] q_b[$];
    logic [9:0] exp_a, exp_b;
    int         vld_a_cnt = 0, vld_b_cnt = 0;
    int         ovr_a_cyc = 0, brk_a_cyc = 0, ovr_b_cyc = 0, brk_b_cyc = 0;

    // transfers are compared as they happen
    always @(negedge clk) begin
        if (rst_n) begin
            if (val_a && rdy_a) begin
                vld_a_cnt++;
                n_checks++;
                if (q_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL word_a: unexpected word data=%h perr=%b ferr=%b, required no word", d_a, pe_a, fe_a);
                end else begin
                    exp_a = q_a.pop_front();
                    if ({pe_a, fe_a, d_a} !== exp_a) begin
                        n_fail++;
                        $display("FAIL word_a: got perr/ferr/data=%b/%b/%h, required %b/%b/%h",
                                 pe_a, fe_a, d_a, exp_a[9], exp_a[8], exp_a[7:0]);
                    end
                end
            end
            if (val_b && rdy_b) begin
                vld_b_cnt++;
                n_checks++;
                if (q_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL word_b: unexpected word data=%h perr=%b ferr=%b, required no word", d_b, pe_b, fe_b);
                end else begin
                    exp_b = q_b.pop_front();
                    if ({pe_b, fe_b, d_b} !== exp_b) begin
                        n_fail++;
                        $display("FAIL word_b: got perr/ferr/data=%b/%b/%h, required %b/%b/%h",
                                 pe_b, fe_b, d_b, exp_b[9], exp_b[8], exp_b[7:0]);
                    end
                end
            end
            if (ovr_a) ovr_a_cyc++;
            if (brk_a) brk_a_cyc++;
            if (ovr_b) ovr_b_cyc++;
            if (brk_b) brk_b_cyc++;
        end
    end

    initial begin
        repeat (99000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 99000 cycles, required completion");
        $fatal(1, "watchdog");
    end

    // drive n bits of f LSB-first, one bit period each, then return the line to idle
    task automatic send(input bit sel, input logic [15:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel) rx_b = f[i]; else rx_a = f[i];
            repeat (BIT) @(negedge clk);
        end
        if (sel) rx_b = 1'b1; else rx_a = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({d_a, pe_a, fe_a, val_a, ovr_a, brk_a, busy_a} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_a: outputs=%b, required all zero", {d_a, pe_a, fe_a, val_a, ovr_a, brk_a, busy_a});
        end
        n_checks++;
        if ({d_b, pe_b, fe_b, val_b, ovr_b, brk_b, busy_b} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_b: outputs=%b, required all zero", {d_b, pe_b, fe_b, val_b, ovr_b, brk_b, busy_b});
        end
        rst_n = 1'b1;
        repeat (BIT) @(negedge clk);
        n_checks++;
        if (val_a !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: valid=%b busy=%b, required 0 0", val_a, busy_a);
        end
    endtask

    task automatic test_basic();
        int v0 = vld_a_cnt;
        q_a.push_back({2'b00, 8'hA5});
        send(1'b0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10);
        repeat (BIT) @(negedge clk);
        n_checks++;
        if (vld_a_cnt - v0 !== 1 || q_a.size() !== 0) begin
            n_fail++;
            $display("FAIL basic_a5: words=%0d pending=%0d, required 1 0", vld_a_cnt - v0, q_a.size());
        end
    endtask

    task automatic test_parity();
        int v0 = vld_b_cnt;
        q_b.push_back({2'b10, 8'h03});
        send(1'b1, {5'd0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        repeat (BIT) @(negedge clk);
        q_b.push_back({2'b00, 8'h03});
        send(1'b1, {5'd0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
        repeat (BIT) @(negedge clk);
        n_checks++;
        if (vld_b_cnt - v0 !== 2 || q_b.size() !== 0) begin
            n_fail++;
            $display("FAIL parity_words: words=%0d pending=%0d, required 2 0", vld_b_cnt - v0, q_b.size());
        end
    endtask

    task automatic test_glitch();
        int v0 = vld_a_cnt;
        rx_a = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_latency_early: busy=%b after 2 clocks, required 0", busy_a);
        end
        @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL edge_latency: busy=%b after 3 clocks, required 1", busy_a);
        end
        repeat (97) @(negedge clk);
        rx_a = 1'b1;
        repeat (BIT) @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0 || vld_a_cnt !== v0) begin
            n_fail++;
            $display("FAIL glitch: busy=%b words=%0d, required 0 0", busy_a, vld_a_cnt - v0);
        end
    endtask

    task automatic test_frame_err();
        q_a.push_back({2'b01, 8'h55});
        send(1'b0, {6'd0, 1'b0, 8'h55, 1'b0}, 10);
        repeat (BIT) @(negedge clk);
        n_checks++;
        if (q_a.size() !== 0) begin
            n_fail++;
            $display("FAIL frame_err: pending=%0d, required 0", q_a.size());
        end
    endtask

    task automatic test_break();
        int v0 = vld_a_cnt;
        int b0 = brk_a_cyc;
        rx_a = 1'b0;
        repeat (20 * BIT) @(negedge clk);
        rx_a = 1'b1;
        repeat (BIT + 40) @(negedge clk);
        n_checks++;
        if (brk_a_cyc - b0 !== 1) begin
            n_fail++;
            $display("FAIL break_pulse: break cycles=%0d, required 1", brk_a_cyc - b0);
        end
        n_checks++;
        if (vld_a_cnt !== v0) begin
            n_fail++;
            $display("FAIL break_no_word: words=%0d, required 0", vld_a_cnt - v0);
        end
        q_a.push_back({2'b00, 8'h11});
        send(1'b0, {6'd0, 1'b1, 8'h11, 1'b0}, 10);
        repeat (BIT) @(negedge clk);
        n_checks++;
        if (vld_a_cnt - v0 !== 1 || q_a.size() !== 0) begin
            n_fail++;
            $display("FAIL after_break: words=%0d pending=%0d, required 1 0", vld_a_cnt - v0, q_a.size());
        end
    endtask

    task automatic test_back_to_back();
        int v0 = vld_a_cnt;
        q_a.push_back({2'b00, 8'h3C});
        q_a.push_back({2'b00, 8'hC3});
        send(1'b0, {6'd0, 1'b1, 8'h3C, 1'b0}, 10);
        send(1'b0, {6'd0, 1'b1, 8'hC3, 1'b0}, 10);
        repeat (BIT) @(negedge clk);
        n_checks++;
        if (vld_a_cnt - v0 !== 2 || q_a.size() !== 0) begin
            n_fail++;
            $display("FAIL back_to_back: words=%0d pending=%0d, required 2 0", vld_a_cnt - v0, q_a.size());
        end
    endtask

    task automatic test_overrun();
        int o0 = ovr_a_cyc;
        @(posedge clk);
        #1 rdy_a = 1'b0;
`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 4; i++) begin
            q_a.push_back({2'b00, 8'(i)});
            send(1'b0, {6'd0, 1'b1, 8'(i), 1'b0}, 10);
        end
        repeat (BIT) @(negedge clk);
        n_checks++;
        if (ovr_a_cyc !== o0) begin
            n_fail++;
            $display("FAIL fifo_no_early_overrun: overrun cycles=%0d, required 0", ovr_a_cyc - o0);
        end
        send(1'b0, {6'd0, 1'b1, 8'h05, 1'b0}, 10);
`else
        q_a.push_back({2'b00, 8'h01});
        send(1'b0, {6'd0, 1'b1, 8'h01, 1'b0}, 10);
        send(1'b0, {6'd0, 1'b1, 8'h02, 1'b0}, 10);
`endif
        repeat (BIT) @(negedge clk);
        n_checks++;
        if (ovr_a_cyc - o0 !== 1) begin
            n_fail++;
            $display("FAIL overrun_pulse: overrun cycles=%0d, required 1", ovr_a_cyc - o0);
        end
        n_checks++;
        if (val_a !== 1'b1 || d_a !== 8'h01) begin
            n_fail++;
            $display("FAIL overrun_hold: valid=%b data=%h, required 1 01", val_a, d_a);
        end
        @(posedge clk);
        #1 rdy_a = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (val_a !== 1'b0 || q_a.size() !== 0) begin
            n_fail++;
            $display("FAIL overrun_drain: valid=%b pending=%0d, required 0 0", val_a, q_a.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_frame_err();
        test_break();
        test_back_to_back();
        test_overrun();
        n_checks++;
        if (ovr_b_cyc !== 0 || brk_b_cyc !== 0) begin
            n_fail++;
            $display("FAIL b_events: overrun=%0d break=%0d, required 0 0", ovr_b_cyc, brk_b_cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
